// File: rtl/xalu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MD_* operation codes carried on the 3-bit op port
//   - default busy latencies for multiply and divide
//   - predicates for "long" (multi-cycle) and divide operations
//   - packed {hi, lo} result type
package xalu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MultLatDefault = 5;
  localparam int unsigned DivLatDefault  = 10;

  // One bit per op code: set for ops that run a busy period.
  localparam logic [7:0] MdLongMask = 8'b0000_1111;
  // One bit per op code: set for the divide ops.
  localparam logic [7:0] MdDivMask  = 8'b0000_1100;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic md_is_long(input logic [2:0] op);
    return MdLongMask[op];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return MdDivMask[op];
  endfunction

endpackage

// File: rtl/xalu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op_i     operation code (MD_*)
//   a_i      rs operand
//   b_i      rt operand
//   res_o    64-bit {hi, lo} result for MULT/MULTU/DIV/DIVU (zero otherwise)
//   div0_o   divide op with b_i == 0
module xalu_arith
  import xalu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output md_res_t     res_o,
  output logic        div0_o
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [31:0] squot;
  logic signed [31:0] srem;
  logic               b_zero;
  logic               s_ovf;

  assign b_zero = (b_i == 32'd0);
  // The one signed quotient that does not fit in 32 bits.
  assign s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  assign sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uprod = {32'd0, a_i} * {32'd0, b_i};

  always_comb begin
    squot = 32'sd0;
    srem  = 32'sd0;
    if (s_ovf) begin
      squot = 32'sh8000_0000;
      srem  = 32'sd0;
    end else if (!b_zero) begin
      // Verilog signed division truncates toward zero; remainder follows dividend sign.
      squot = $signed(a_i) / $signed(b_i);
      srem  = $signed(a_i) % $signed(b_i);
    end
  end

  always_comb begin
    res_o  = '0;
    div0_o = 1'b0;
    case (op_i)
      MD_MULT:  res_o = md_res_t'(sprod);
      MD_MULTU: res_o = md_res_t'(uprod);
      MD_DIV: begin
        div0_o = b_zero;
        res_o  = '{hi: srem, lo: squot};
      end
      MD_DIVU: begin
        div0_o = b_zero;
        if (!b_zero) begin
          res_o = '{hi: a_i % b_i, lo: a_i / b_i};
        end
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/xalu_md.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   start       EX instruction is mult/div/mthi/mtlo this cycle
//   op          MD_* operation code
//   A, B        forwarded rs / rt operands
//   hi_sel      XALUOUT read select: 1 = HI, 0 = LO
//   busy        long operation in flight
//   md_stall    busy, or a long op is being started this cycle
//   XALUOUT     HI or LO, straight from the registers
module xalu_md
  import xalu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MultLatDefault,
  parameter int unsigned DIV_LAT  = DivLatDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_sel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] XALUOUT
);

  localparam int unsigned CntW = $clog2(DIV_LAT + 1);
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_LAT - 1);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_LAT - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;

  md_res_t arith_res;
  logic    arith_div0;

  xalu_arith u_arith (
    .op_i   (op),
    .a_i    (A),
    .b_i    (B),
    .res_o  (arith_res),
    .div0_o (arith_div0)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (md_is_long(op)) begin
            // Divide by zero retires the current HI/LO, which nothing can change while busy.
            pend_hi_d = arith_div0 ? hi_q : arith_res.hi;
            pend_lo_d = arith_div0 ? lo_q : arith_res.lo;
            cnt_d     = md_is_div(op) ? DivCnt : MultCnt;
            state_d   = StBusy;
          end else if (op == MD_MTHI) begin
            hi_d = A;
          end else if (op == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign md_stall = busy | (start & md_is_long(op));
  assign XALUOUT  = hi_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_xalu_md.sv
// Self-checking bench for xalu_md: directed vector table, hand-written
// multi-cycle sequences and random ops checked against an arithmetic model.
module tb_xalu_md;

  localparam int unsigned MultLat = 5;
  localparam int unsigned DivLat  = 10;
  localparam int          Bound   = 50;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_sel;
  logic        busy;
  logic        md_stall;
  logic [31:0] xaluout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo;  // model of architectural HI/LO

  xalu_md #(
    .MULT_LAT (MultLat),
    .DIV_LAT  (DivLat)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (a),
    .B        (b),
    .hi_sel   (hi_sel),
    .busy     (busy),
    .md_stall (md_stall),
    .XALUOUT  (xaluout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
    return o <= OpDivu;
  endfunction

  function automatic int lat_of(input logic [2:0] o);
    if (o == OpMult || o == OpMultu) return MultLat;
    if (o == OpDiv || o == OpDivu) return DivLat;
    return 0;
  endfunction

  // Architectural effect of one op on HI/LO, from plain integer arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sx, sy, q, r;
    longint unsigned p;
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    case (o)
      OpMult: begin
        p  = longint'(sx * sy);
        hi = p[63:32];
        lo = p[31:0];
      end
      OpMultu: begin
        p  = {32'd0, x} * {32'd0, y};
        hi = p[63:32];
        lo = p[31:0];
      end
      OpDiv: if (y != 0) begin
        q  = sx / sy;
        r  = sx % sy;
        hi = r[31:0];
        lo = q[31:0];
      end
      OpDivu: if (y != 0) begin
        hi = x % y;
        lo = x / y;
      end
      OpMthi: hi = x;
      OpMtlo: lo = x;
      default: ;
    endcase
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    hi_sel = 1'b1;
    #1 hi = xaluout;
    hi_sel = 1'b0;
    #1 lo = xaluout;
  endtask

  // Called at a negedge: drives one start cycle and returns at the next negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string name);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1 check({name, " md_stall@start"}, {31'd0, md_stall}, {31'd0, is_long(o)});
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
  endtask

  // Counts busy cycles (checking stall and old-value reads) until busy drops.
  task automatic wait_idle(input string name, input logic [31:0] old_lo, output int n);
    n = 0;
    while (busy === 1'b1 && n < Bound) begin
      if (n == 0) check({name, " old LO while busy"}, xaluout, old_lo);
      if (md_stall !== 1'b1) check({name, " md_stall while busy"}, {31'd0, md_stall}, 32'd1);
      n++;
      @(negedge clk);
    end
    if (n >= Bound) check({name, " busy timeout"}, 32'(n), 32'(Bound - 1));
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_busy);
    int          n;
    logic [31:0] hi, lo, old_lo;
    old_lo = m_lo;
    issue(o, x, y, name);
    wait_idle(name, old_lo, n);
    check({name, " busy cycles"}, 32'(n), 32'(exp_busy));
    read_hilo(hi, lo);
    check({name, " HI"}, hi, exp_hi);
    check({name, " LO"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  vec_t vecs[$];

  initial begin
    int          n;
    logic [31:0] hi, lo, eh, el;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd7;
    a      = '0;
    b      = '0;
    hi_sel = 1'b0;
    m_hi   = '0;
    m_lo   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset md_stall", {31'd0, md_stall}, 32'd0);
    read_hilo(hi, lo);
    check("reset HI", hi, 32'd0);
    check("reset LO", lo, 32'd0);

    // Directed vectors; expected values derived by hand.
    vecs.push_back('{OpMult,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
    vecs.push_back('{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5});
    vecs.push_back('{OpDiv,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    vecs.push_back('{OpMthi,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFD, 0});
    vecs.push_back('{OpMtlo,  32'h0000_5678, 32'd0,        32'h0000_1234, 32'h0000_5678, 0});
    vecs.push_back('{OpDivu,  32'd7,         32'd0,        32'h0000_1234, 32'h0000_5678, 10});
    vecs.push_back('{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10});
    vecs.push_back('{OpDivu,  32'd100,       32'd7,        32'd2,         32'd14,        10});
    vecs.push_back('{OpMult,  32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'd0,         32'd21,        5});
    vecs.push_back('{3'd7,    32'd1,         32'd1,        32'd0,         32'd21,        0});
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i),
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_busy);
    end

    // DIV issued mid-MULT is ignored; MULT lands on time; next MULT accepted at once.
    issue(OpMult, 32'd6, 32'd7, "overlap mult");
    @(negedge clk);  // second busy cycle
    start = 1'b1;
    op    = OpDiv;
    a     = 32'd100;
    b     = 32'd7;
    #1 check("overlap md_stall", {31'd0, md_stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
    wait_idle("overlap", 32'd21, n);
    check("overlap busy cycles", 32'(n + 2), 32'(MultLat));
    read_hilo(hi, lo);
    check("overlap HI", hi, 32'd0);
    check("overlap LO", lo, 32'd42);
    m_hi = 32'd0;
    m_lo = 32'd42;
    run_op(OpMult, 32'd9, 32'd9, "back2back", 32'd0, 32'd81, MultLat);

    // Reset in the third busy cycle of MULT 3x4.
    run_op(OpMthi, 32'hAAAA, 32'd0, "pre-reset mthi", 32'hAAAA, 32'd81, 0);
    issue(OpMult, 32'd3, 32'd4, "reset mult");
    repeat (2) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1 check("reset-mid busy", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check("reset-mid HI", hi, 32'd0);
    check("reset-mid LO", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (MultLat + 3) @(negedge clk);
    check("post-reset busy", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check("post-reset HI", hi, 32'd0);
    check("post-reset LO", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;

    // Random ops against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: begin ra = 32'($urandom_range(0, 40)); rb = 32'($urandom_range(1, 9)); end
        2: ra = -32'($urandom_range(0, 40));
        default: ;
      endcase
      eh = m_hi;
      el = m_lo;
      model_op(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro), eh, el, lat_of(ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xalu_md.md
# xalu_md

Multiply/divide unit in the EX stage, directly downstream of the decode/writeback stage. It consumes the decoded instruction's forwarded rs/rt operands. It also owns the architectural HI/LO registers. It supplies the value that the pipeline forwards and writes back as XALUOUT. It models multi-cycle MULT/MULTU/DIV/DIVU latency with a busy counter, which the hazard unit uses to stall mfhi/mflo/mult/div behind an in-flight operation.

## Interface
Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (≥1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (≥1, ≥MULT_LAT)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- start  in  1  EX-stage instruction is a mult/div/mthi/mtlo this cycle
- op  in  3  operation code (xalu_pkg: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- hi_sel  in  1  read select for XALUOUT: 1 = HI, 0 = LO
- busy  out  1  long operation in flight
- md_stall  out  1  busy | (start & op is MULT/MULTU/DIV/DIVU); used by hazard unit
- XALUOUT  out  32  hi_sel ? HI : LO (combinational from registers)

## Operation
- State: HI[31:0], LO[31:0], busy, cnt[$clog2(DIV_LAT+1)-1:0], pend_hi[31:0], pend_lo[31:0].
- Idle (busy=0), start=1, op ∈ {MULT, MULTU, DIV, DIVU}:
  - compute a 64-bit result from A, B and capture it into pend_hi/pend_lo;
  - set busy=1 and cnt = LAT-1, where LAT is the latency for that op.
- Busy, cnt≠0: decrement cnt.
- Busy, cnt=0: HI←pend_hi, LO←pend_lo, busy←0.
- MULT: {HI,LO} = signed(A)·signed(B), 64-bit. MULTU: unsigned 64-bit product.
- DIV: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0): the full DIV_LAT busy period still runs; HI/LO keep their prior values at completion.
- MTHI/MTLO with start=1 and busy=0: HI←A (or LO←A) at that edge. No busy period.
- start=1 while busy=1: ignored entirely; HI/LO/cnt are not disturbed. The hazard unit guarantees this does not occur architecturally.
- Reading XALUOUT during busy returns the old HI/LO. mfhi/mflo must be stalled via md_stall.
- Unknown op codes with start=1: no effect.

## Timing
- Reset values: HI=0, LO=0, busy=0, cnt=0, pend_*=0. Therefore md_stall=0 and XALUOUT=0 after reset.
- Reset asserted mid-operation aborts the operation: busy drops asynchronously and the pending result is discarded.
- Operation started by the edge at the end of cycle T:
  - busy=1 in cycles T+1 … T+LAT;
  - HI/LO hold the new value and busy=0 from cycle T+LAT+1.
- md_stall is combinational. It is high in cycle T (from start) and in every busy cycle.
- Back-to-back: a new start is accepted in the first cycle where busy=0. There is no dead cycle.
- MTHI/MTLO: new value is visible on XALUOUT in cycle T+1.
- XALUOUT has no added latency from HI/LO.

## Structure
- Package xalu_pkg holds:
  - the 3-bit MD_* op localparams;
  - helper predicate constants for "is long op";
  - default latencies.
- Sub-module xalu_arith (combinational) takes op, A, B and produces the 64-bit {hi,lo} result plus a div-by-zero flag.
- Top-level xalu_md holds the counter/busy state machine (IDLE, BUSY) and the HI/LO/pending registers.

## Test plan
- Reset mid-op:
  - MULT 3×4 started, reset asserted in its 3rd busy cycle;
  - expect busy=0 immediately, HI=LO=0, and no later write.
- MULT signed 0xFFFFFFFE × 3:
  - busy high for exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2:
  - busy high for 10 cycles;
  - LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU 7 / 0 after MTHI 0x1234 and MTLO 0x5678:
  - busy runs 10 cycles;
  - HI=0x1234 and LO=0x5678 unchanged.
- start DIV issued during an in-flight MULT:
  - ignored; MULT result lands at its original cycle;
  - md_stall is high throughout;
  - a new MULT issued on the first cycle with busy=0 is accepted with no dead cycle.
